// File: rtl/linear_network_multicast_pipe_pkg.sv
// rtl/linear_network_multicast_pipe_pkg.sv - shared defaults for the multicast distribution chain
package linear_network_multicast_pipe_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_NODE   = 4;

endpackage

// File: rtl/linear_network_multicast_node.sv
// rtl/linear_network_multicast_node.sv - one chain stage: local delivery plus downstream forward
module linear_network_multicast_node
  import linear_network_multicast_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_NODE   = DEFAULT_NUM_NODE,
  parameter int NODE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [NUM_NODE-1:0]   up_mask,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [NUM_NODE-1:0]   dn_mask,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic                  loc_valid,
  input  logic                  loc_ready,
  output logic [DATA_WIDTH-1:0] loc_data
);

  localparam int MASK_W = NUM_NODE;
  // Destinations strictly beyond this node; empty for the last stage.
  localparam logic [MASK_W-1:0] HI_MASK = {MASK_W{1'b1}} << (NODE_ID + 1);

  logic                  vld;
  logic                  loc_done;
  logic                  fwd_done;
  logic [MASK_W-1:0]     mask;
  logic [DATA_WIDTH-1:0] data;

  logic need_loc;
  logic need_fwd;
  logic loc_fire;
  logic fwd_fire;
  logic loc_ok;
  logic fwd_ok;
  logic leave;
  logic load;

  assign need_loc  = mask[NODE_ID];
  assign need_fwd  = |(mask & HI_MASK);

  assign loc_valid = en & vld & need_loc & ~loc_done;
  assign loc_data  = loc_valid ? data : '0;
  assign loc_fire  = loc_valid & loc_ready;

  assign dn_valid  = en & vld & need_fwd & ~fwd_done;
  assign dn_mask   = mask & HI_MASK;
  assign dn_data   = data;
  assign fwd_fire  = dn_valid & dn_ready;

  assign loc_ok    = ~need_loc | loc_done | loc_fire;
  assign fwd_ok    = ~need_fwd | fwd_done | fwd_fire;
  assign leave     = en & vld & loc_ok & fwd_ok;

  // Ready depends on this cycle's leave, so a full chain still moves one flit per cycle.
  assign up_ready  = en & (~vld | leave);
  assign load      = up_valid & up_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= 1'b0;
      loc_done <= 1'b0;
      fwd_done <= 1'b0;
    end else if (load) begin
      vld      <= 1'b1;
      loc_done <= 1'b0;
      fwd_done <= 1'b0;
    end else if (leave) begin
      vld      <= 1'b0;
      loc_done <= 1'b0;
      fwd_done <= 1'b0;
    end else if (en & vld) begin
      loc_done <= loc_done | loc_fire;
      fwd_done <= fwd_done | fwd_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data <= up_data;
      mask <= up_mask;
    end
  end

endmodule

// File: rtl/linear_network_multicast_pipe.sv
// rtl/linear_network_multicast_pipe.sv - pipelined multicast chain of NUM_NODE stages with injection port
module linear_network_multicast_pipe
  import linear_network_multicast_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_NODE   = DEFAULT_NUM_NODE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [NUM_NODE-1:0]            i_dest,
  output logic [NUM_NODE-1:0]            o_valid,
  input  logic [NUM_NODE-1:0]            i_ready,
  output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus
);

  localparam int MASK_W = NUM_NODE;

  for (genvar k = 0; k < NUM_NODE; k++) begin : g_node
    logic                  up_valid;
    logic                  up_ready;
    logic [MASK_W-1:0]     up_mask;
    logic [DATA_WIDTH-1:0] up_data;
    logic                  dn_valid;
    logic                  dn_ready;
    logic [MASK_W-1:0]     dn_mask;
    logic [DATA_WIDTH-1:0] dn_data;

    if (k == 0) begin : g_inject
      // An empty mask is handshaken at the port but never loaded.
      assign up_valid = i_valid & (|i_dest);
      assign up_mask  = i_dest;
      assign up_data  = i_data_bus;
    end else begin : g_link
      assign up_valid = g_node[k-1].dn_valid;
      assign up_mask  = g_node[k-1].dn_mask;
      assign up_data  = g_node[k-1].dn_data;
    end

    if (k == NUM_NODE - 1) begin : g_tail
      logic unused_tail;
      assign dn_ready    = 1'b0;
      assign unused_tail = ^{dn_valid, dn_mask, dn_data};
    end else begin : g_mid
      assign dn_ready = g_node[k+1].up_ready;
    end

    linear_network_multicast_node #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_NODE   (NUM_NODE),
      .NODE_ID    (k)
    ) u_node (
      .clk       (clk),
      .rst       (rst),
      .en        (i_en),
      .up_valid  (up_valid),
      .up_ready  (up_ready),
      .up_mask   (up_mask),
      .up_data   (up_data),
      .dn_valid  (dn_valid),
      .dn_ready  (dn_ready),
      .dn_mask   (dn_mask),
      .dn_data   (dn_data),
      .loc_valid (o_valid[k]),
      .loc_ready (i_ready[k]),
      .loc_data  (o_data_bus[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign o_ready = g_node[0].up_ready;

endmodule

// File: tb/tb_linear_network_multicast_pipe.sv
// tb/tb_linear_network_multicast_pipe.sv - directed timing checks plus randomized scoreboard for the chain
module tb_linear_network_multicast_pipe;

  localparam int DW = 32;
  localparam int NN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_en;
  logic             i_valid;
  logic             o_ready;
  logic [DW-1:0]    i_data_bus;
  logic [NN-1:0]    i_dest;
  logic [NN-1:0]    o_valid;
  logic [NN-1:0]    i_ready;
  logic [NN*DW-1:0] o_data_bus;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;
  logic [DW-1:0] exp_q [NN][$];

  linear_network_multicast_pipe #(.DATA_WIDTH(DW), .NUM_NODE(NN)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_bus (i_data_bus),
    .i_dest     (i_dest),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data_bus (o_data_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice(input int k);
    return o_data_bus[k*DW +: DW];
  endfunction

  function automatic logic [NN*DW-1:0] place(input int k, input logic [DW-1:0] d);
    logic [NN*DW-1:0] b;
    b = '0;
    b[k*DW +: DW] = d;
    return b;
  endfunction

  task automatic cyc_end;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: each accepted flit joins the FIFO of every node in its mask.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst) begin
        for (int k = 0; k < NN; k++) exp_q[k].delete();
      end else begin
        if (i_valid && o_ready)
          for (int k = 0; k < NN; k++)
            if (i_dest[k]) exp_q[k].push_back(i_data_bus);
        for (int k = 0; k < NN; k++) begin
          if (o_valid[k] && i_ready[k]) begin
            if (exp_q[k].size() == 0) check("sb_unexpected_copy", o_valid[k], 1'b0);
            else check("sb_data", slice(k), exp_q[k].pop_front());
          end
          if (!o_valid[k]) check("sb_idle_zero", slice(k), '0);
        end
      end
    end
  end

  // One flit with all sinks ready: node k must show it exactly one cycle, k+1 cycles later.
  task automatic single_flit(input string tag, input logic [NN-1:0] dest, input logic [DW-1:0] d);
    logic [NN-1:0] ev;
    for (int c = 0; c < 7; c++) begin
      i_valid = (c == 0); i_dest = dest; i_data_bus = d; i_ready = '1; i_en = 1'b1;
      @(negedge clk);
      if (c == 0) check({tag, "_ready"}, o_ready, 1'b1);
      ev = '0;
      if (c >= 1 && c <= NN && dest[c-1]) ev[c-1] = 1'b1;
      check({tag, "_ov"}, o_valid, ev);
      if (ev != 0) check({tag, "_bus"}, o_data_bus, place(c - 1, d));
      cyc_end();
    end
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < n; c++) begin
      i_valid = 1'b0; i_ready = '1; i_en = 1'b1;
      cyc_end();
    end
    for (int k = 0; k < NN; k++) check("drain_empty", exp_q[k].size(), 0);
  endtask

  initial begin
    int f;
    rst = 1'b1; i_en = 1'b1; i_valid = 1'b1; i_dest = '1; i_data_bus = 32'h12345678; i_ready = '1;
    cyc_end();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_ov", o_valid, '0);
      check("rst_bus", o_data_bus, '0);
      cyc_end();
    end
    rst = 1'b0; i_valid = 1'b0; mon_on = 1'b1;
    @(negedge clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_ov_after", o_valid, '0);
    cyc_end();

    single_flit("uni", 4'b0100, 32'hAAAAAAAA);
    single_flit("mcast", 4'b1011, 32'hBBBBBBBB);
    single_flit("bcast", 4'b1111, 32'h0BCA5700);
    single_flit("drop", 4'b0000, 32'hDEADBEEF);

    // Node 1 stalled for 7 cycles; node 3's copy must not wait for it.
    for (int c = 0; c < 12; c++) begin
      i_en = 1'b1;
      i_valid = (c <= 7);
      i_dest = (c == 0) ? 4'b1010 : 4'b0010;
      i_data_bus = (c == 0) ? 32'hC0C0C0C0 : ((c == 1) ? 32'hC1C1C1C1 : 32'hC2C2C2C2);
      i_ready = (c >= 7) ? 4'b1111 : 4'b1101;
      @(negedge clk);
      check("bp_ready", o_ready, !(c >= 2 && c <= 6));
      check("bp_ov1", o_valid[1], (c >= 2 && c <= 9));
      check("bp_ov3", o_valid[3], (c == 4));
      if (c >= 2 && c <= 9)
        check("bp_data1", slice(1), (c <= 7) ? 32'hC0C0C0C0 : ((c == 8) ? 32'hC1C1C1C1 : 32'hC2C2C2C2));
      cyc_end();
    end
    drain(8);

    for (int c = 0; c < 13; c++) begin
      i_en = 1'b1; i_valid = (c < 8); i_dest = 4'b1000; i_data_bus = c; i_ready = '1;
      @(negedge clk);
      if (c < 8) check("str_ready", o_ready, 1'b1);
      check("str_ov3", o_valid[3], (c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) check("str_data3", slice(3), c - 4);
      cyc_end();
    end

    f = 0;
    for (int c = 0; c < 16; c++) begin
      i_en = !(c >= 5 && c <= 7); i_valid = (f < 8); i_dest = 4'b1000; i_data_bus = 16 + f; i_ready = '1;
      @(negedge clk);
      if (!i_en) begin
        check("en_ov", o_valid, '0);
        check("en_ready", o_ready, 1'b0);
        check("en_bus", o_data_bus, '0);
      end
      check("en_ov3", o_valid[3], (c == 4) || (c >= 8 && c <= 14));
      if (c == 4) check("en_data3", slice(3), 16);
      if (c >= 8 && c <= 14) check("en_data3", slice(3), 17 + c - 8);
      if (i_valid && o_ready) f++;
      cyc_end();
    end
    drain(6);

    for (int c = 0; c < 500; c++) begin
      i_en = ($urandom_range(0, 15) != 0);
      i_valid = $urandom_range(0, 1);
      i_dest = $urandom_range(0, 15);
      i_data_bus = $urandom;
      i_ready = $urandom_range(0, 15) | (($urandom_range(0, 1) != 0) ? 4'b1111 : 4'b0000);
      cyc_end();
    end
    drain(30);

    // Reset while flits are in flight discards them all.
    for (int c = 0; c < 3; c++) begin
      i_en = 1'b1; i_valid = 1'b1; i_dest = '1; i_data_bus = $urandom; i_ready = '0;
      cyc_end();
    end
    rst = 1'b1;
    cyc_end();
    rst = 1'b0; i_valid = 1'b0; i_ready = '1;
    @(negedge clk);
    check("midrst_ov", o_valid, '0);
    check("midrst_bus", o_data_bus, '0);
    check("midrst_ready", o_ready, 1'b1);
    cyc_end();
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
